// File: rtl/mem_resp_pkg.sv
// Shared types and default sizing for the memory responder block.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } respState_t;

    typedef logic [15:0] word_t;

    localparam int DEF_MEM_LAT = 4;
    localparam int DEF_LINES   = 16;
    localparam int DEF_MEM_AW  = 12;

endpackage

// File: rtl/mem_responder_if.sv
// Requester/responder handshake bundle for mem_responder.
interface mem_responder_if;
    import mem_resp_pkg::*;

    logic [15:0] Addr;
    word_t       DataIn;
    logic        Rd;
    logic        Wr;
    word_t       DataOut;
    logic        Done;
    logic        Stall;
    logic        CacheHit;
    logic        err;

    modport master (
        output Addr, DataIn, Rd, Wr,
        input  DataOut, Done, Stall, CacheHit, err
    );

    modport slave (
        input  Addr, DataIn, Rd, Wr,
        output DataOut, Done, Stall, CacheHit, err
    );

endinterface

// File: rtl/mem_resp_lines.sv
// Direct-mapped one-word line storage: combinational lookup port and a single write port.
module mem_resp_lines
    import mem_resp_pkg::*;
#(
    parameter  int LINES = DEF_LINES,
    localparam int IW    = $clog2(LINES),
    localparam int TW    = 15 - IW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] lookupIndex,
    input  logic [TW-1:0] lookupTag,
    output logic          lookupHit,
    output word_t         lookupData,
    input  logic          writeEn,
    input  logic [IW-1:0] writeIndex,
    input  logic [TW-1:0] writeTag,
    input  word_t         writeData
);

    logic [LINES-1:0] valid;
    logic [TW-1:0]    tags [LINES];
    word_t            data [LINES];

    // Only the valid bits are cleared; tag and data contents survive reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
        end else if (writeEn) begin
            valid[writeIndex] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (writeEn) begin
            tags[writeIndex] <= writeTag;
            data[writeIndex] <= writeData;
        end
    end

    assign lookupHit  = valid[lookupIndex] && (tags[lookupIndex] == lookupTag);
    assign lookupData = data[lookupIndex];

endmodule

// File: rtl/mem_responder.sv
// Memory responder with fixed-latency backing memory and optional write-through read cache.
// Define MEM_RESP_CACHE_EN to build the cache; without it every read takes the memory path.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int MEM_LAT = DEF_MEM_LAT,
    parameter int LINES   = DEF_LINES,
    parameter int MEM_AW  = DEF_MEM_AW
) (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave bus
);

    respState_t state;
    respState_t nextState;

    logic [14:0]       reqWord;
    word_t             reqData;
    logic              reqWrite;
    logic [3:0]        cnt;
    word_t             respData;
    logic              respHit;
    logic              respErr;

    logic              request;
    logic              reqBad;
    logic              readHit;
    logic              busyDone;
    logic              lookupHit;
    word_t             lookupData;
    logic              done;
    logic [MEM_AW-1:0] memWord;
    word_t             memRead;
    word_t             mem [2**MEM_AW];

    assign request  = bus.Rd | bus.Wr;
    assign reqBad   = bus.Addr[0] | (bus.Rd & bus.Wr);
    assign readHit  = bus.Rd & ~reqBad & lookupHit;
    assign busyDone = (state == BUSY) && (cnt == 4'(MEM_LAT - 2));
    assign memWord  = reqWord[MEM_AW-1:0];
    assign memRead  = mem[memWord];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Rejected requests and read hits answer on the next cycle; everything else waits out the memory.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (request) nextState = (reqBad || readHit) ? RESP : BUSY;
            BUSY:    if (busyDone) nextState = RESP;
            RESP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // The request is captured at acceptance so the requester may change its inputs afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            reqWord  <= '0;
            reqData  <= '0;
            reqWrite <= 1'b0;
            respData <= '0;
            respHit  <= 1'b0;
            respErr  <= 1'b0;
        end else if (state == IDLE && request) begin
            reqWord  <= bus.Addr[15:1];
            reqData  <= bus.DataIn;
            reqWrite <= bus.Wr;
            cnt      <= '0;
            respErr  <= reqBad;
            respHit  <= readHit;
            respData <= readHit ? lookupData : '0;
        end else if (state == BUSY) begin
            cnt <= cnt + 4'd1;
            if (busyDone) begin
                respData <= reqWrite ? '0 : memRead;
                respHit  <= 1'b0;
                respErr  <= 1'b0;
            end
        end
    end

    // Writes land on the BUSY->RESP edge, so a reset during BUSY never reaches memory.
    always_ff @(posedge clk) begin
        if (busyDone && reqWrite) begin
            mem[memWord] <= reqData;
        end
    end

`ifdef MEM_RESP_CACHE_EN
    localparam int IW = $clog2(LINES);

    logic [14:0] lookupWord;
    logic        lineWe;
    word_t       lineData;

    // Fill on read miss; on a write only refresh a line that already holds this tag.
    assign lookupWord = (state == IDLE) ? bus.Addr[15:1] : reqWord;
    assign lineWe     = busyDone && (!reqWrite || lookupHit);
    assign lineData   = reqWrite ? reqData : memRead;

    mem_resp_lines #(
        .LINES (LINES)
    ) lines (
        .clk         (clk),
        .rst         (rst),
        .lookupIndex (lookupWord[IW-1:0]),
        .lookupTag   (lookupWord[14:IW]),
        .lookupHit   (lookupHit),
        .lookupData  (lookupData),
        .writeEn     (lineWe),
        .writeIndex  (reqWord[IW-1:0]),
        .writeTag    (reqWord[14:IW]),
        .writeData   (lineData)
    );
`else
    logic unusedBits;

    assign lookupHit  = 1'b0;
    assign lookupData = '0;
    assign unusedBits = ^{reqWord, respHit};
`endif

    always_comb begin
        done         = (state == RESP);
        bus.Done     = done;
        bus.Stall    = (state == BUSY);
        bus.DataOut  = done ? respData : '0;
        bus.err      = done & respErr;
`ifdef MEM_RESP_CACHE_EN
        bus.CacheHit = done & respHit;
`else
        bus.CacheHit = 1'b0;
`endif
    end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: directed scenarios followed by randomized traffic.
`timescale 1ns/1ps
module tb_mem_responder;
    import mem_resp_pkg::*;

    localparam int MEM_LAT = 4;
    localparam int LINES   = 16;
    localparam int MEM_AW  = 12;
`ifdef MEM_RESP_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    typedef struct {
        int          latency;
        int          doneCycle;
        logic [15:0] data;
        bit          checkData;
        bit          hit;
        bit          err;
    } expect_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cycle = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   stallSeen = 0;

    expect_t     expQ [$];
    expect_t     monExp;
    logic [15:0] memModel [int];
    bit          cValid [LINES];
    int          cTag [LINES];
    logic [15:0] cData [LINES];
    bit          cKnown [LINES];
    logic [15:0] pool [8] = '{16'h0010, 16'h2010, 16'h0030, 16'h0020,
                              16'h1FFE, 16'h3FFE, 16'h0002, 16'hE002};

    mem_responder_if bus ();

    mem_responder #(
        .MEM_LAT (MEM_LAT),
        .LINES   (LINES),
        .MEM_AW  (MEM_AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Reference behaviour: word address wraps modulo memory size, line = word mod LINES, tag = word / LINES.
    function automatic void modelRequest(input bit rd, input bit wr, input logic [15:0] addr,
                                         input logic [15:0] din, output expect_t e);
        int  fullWord = int'(addr) / 2;
        int  memIdx   = fullWord % (2 ** MEM_AW);
        int  line     = fullWord % LINES;
        int  tag      = fullWord / LINES;
        bit  tagHit   = CACHE_EN && cValid[line] && (cTag[line] == tag);
        e = '{latency: MEM_LAT, doneCycle: 0, data: 16'h0, checkData: 1'b1, hit: 1'b0, err: 1'b0};
        if (addr[0] || (rd && wr)) begin
            e.latency = 1;
            e.err     = 1'b1;
        end else if (rd) begin
            if (tagHit) begin
                e.latency   = 1;
                e.hit       = 1'b1;
                e.data      = cData[line];
                e.checkData = cKnown[line];
            end else begin
                e.checkData = memModel.exists(memIdx);
                e.data      = e.checkData ? memModel[memIdx] : 16'h0;
                if (CACHE_EN) begin
                    cValid[line] = 1'b1;
                    cTag[line]   = tag;
                    cData[line]  = e.data;
                    cKnown[line] = e.checkData;
                end
            end
        end else begin
            memModel[memIdx] = din;
            if (tagHit) begin
                cData[line]  = din;
                cKnown[line] = 1'b1;
            end
        end
    endfunction

    task automatic applyStimulus(input bit rd, input bit wr, input logic [15:0] addr, input logic [15:0] din);
        expect_t e;
        int      waitCnt;
        @(negedge clk);
        bus.Rd     = rd;
        bus.Wr     = wr;
        bus.Addr   = addr;
        bus.DataIn = din;
        modelRequest(rd, wr, addr, din, e);
        e.doneCycle = cycle + e.latency;
        expQ.push_back(e);
        @(posedge clk);
        #1;
        bus.Addr   = 16'($urandom);
        bus.DataIn = 16'($urandom);
        waitCnt = 0;
        do begin
            @(negedge clk);
            waitCnt++;
        end while (bus.Done !== 1'b1 && waitCnt < 40);
        if (bus.Done !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL doneTimeout: got no Done, expected Done within 40 cycles (addr 0x%0h)", addr);
            expQ.delete();
        end
        bus.Rd = 1'b0;
        bus.Wr = 1'b0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, ".Done"}, 32'(bus.Done), 0);
        checkOutput({tag, ".Stall"}, 32'(bus.Stall), 0);
        checkOutput({tag, ".DataOut"}, 32'(bus.DataOut), 0);
        checkOutput({tag, ".CacheHit"}, 32'(bus.CacheHit), 0);
        checkOutput({tag, ".err"}, 32'(bus.err), 0);
    endtask

    // Write aborted by reset in its second BUSY cycle: memory must keep its previous contents.
    task automatic resetDuringWrite(input logic [15:0] addr, input logic [15:0] din);
        @(negedge clk);
        bus.Wr     = 1'b1;
        bus.Addr   = addr;
        bus.DataIn = din;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("abortStallBefore", 32'(bus.Stall), 1);
        rst = 1'b0;
        #1;
        checkResetOutputs("abortReset");
        bus.Wr = 1'b0;
        for (int i = 0; i < LINES; i++) cValid[i] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Monitor: pops one expectation per Done pulse and checks timing, data and flags.
    always @(negedge clk) begin
        if (!rst) begin
            stallSeen = 0;
        end else begin
            if (bus.Stall === 1'b1) stallSeen++;
            if (bus.Done === 1'b1) begin
                if (expQ.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL unexpectedDone: got Done=1, expected no response pending");
                end else begin
                    monExp = expQ.pop_front();
                    checkOutput("doneCycle", 32'(cycle), 32'(monExp.doneCycle));
                    checkOutput("stallCycles", 32'(stallSeen), 32'(monExp.latency - 1));
                    if (monExp.checkData) checkOutput("DataOut", 32'(bus.DataOut), 32'(monExp.data));
                    checkOutput("CacheHit", 32'(bus.CacheHit), 32'(monExp.hit));
                    checkOutput("err", 32'(bus.err), 32'(monExp.err));
                end
                stallSeen = 0;
            end else begin
                checkOutput("quietOutputs", 32'({bus.DataOut, bus.CacheHit, bus.err}), 0);
            end
        end
    end

    initial begin
        int          pick;
        int          kind;
        logic [15:0] a;
        bus.Rd     = 1'b0;
        bus.Wr     = 1'b0;
        bus.Addr   = '0;
        bus.DataIn = '0;
        for (int i = 0; i < LINES; i++) cValid[i] = 1'b0;
        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        rst = 1'b1;

        $display("[TB] directed scenarios, cache %s", CACHE_EN ? "enabled" : "disabled");
        applyStimulus(1'b0, 1'b1, 16'h0010, 16'hBEEF);
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0000);
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0000);
        applyStimulus(1'b1, 1'b0, 16'h0030, 16'h0000);
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0000);
        applyStimulus(1'b1, 1'b0, 16'h0011, 16'h0000);
        applyStimulus(1'b1, 1'b1, 16'h0010, 16'hDEAD);
        applyStimulus(1'b1, 1'b0, 16'h2010, 16'h0000);
        applyStimulus(1'b0, 1'b1, 16'h0020, 16'h5A5A);
        resetDuringWrite(16'h0020, 16'h1234);
        applyStimulus(1'b1, 1'b0, 16'h0020, 16'h0000);

        $display("[TB] randomized traffic");
        foreach (pool[i]) applyStimulus(1'b0, 1'b1, pool[i], 16'($urandom));
        for (int n = 0; n < 150; n++) begin
            pick = int'($urandom_range(0, 7));
            kind = int'($urandom_range(0, 99));
            a    = pool[pick];
            if (kind < 45) begin
                applyStimulus(1'b1, 1'b0, a, 16'($urandom));
            end else if (kind < 85) begin
                applyStimulus(1'b0, 1'b1, a, 16'($urandom));
            end else if (kind < 93) begin
                applyStimulus(1'($urandom), 1'b1, a | 16'h0001, 16'($urandom));
            end else begin
                applyStimulus(1'b1, 1'b1, a, 16'($urandom));
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        if (expQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL pendingResponses: got %0d left, expected 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
